// File: rtl/temporizador_multicanal.sv
// -----------------------------------------------------------------------------
// temporizador_multicanal
//
// Multi-channel monostable/periodic timer. CHANNELS independent down-counters
// of WIDTH bits share one programmable prescaler tick. Each channel is started
// by a rising edge on its trigger and runs in one of three modes:
//   00 one-shot, 01 retriggerable one-shot, 10 periodic, 11 same as 00.
//
// Ports:
//   Clk        system clock, all state updates on its rising edge
//   Reset      asynchronous active-high reset of all state
//   Prescaler  tick period minus one (0 = tick every cycle)
//   Disparo    per-channel trigger, rising-edge sensitive
//   Cancelar   per-channel synchronous abort, level sensitive
//   Modo       per-channel mode, channel i at [2i+1:2i]
//   Overflow   per-channel reload value, channel i at [WIDTH*i +: WIDTH]
//   Saida      high while the channel counter is non-zero
//   Fim        one-cycle pulse on channel expiry
// -----------------------------------------------------------------------------
module temporizador_multicanal #(
    parameter int WIDTH          = 28,
    parameter int CHANNELS       = 4,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic [PRESCALE_WIDTH-1:0]    Prescaler,
    input  logic [CHANNELS-1:0]          Disparo,
    input  logic [CHANNELS-1:0]          Cancelar,
    input  logic [2*CHANNELS-1:0]        Modo,
    input  logic [WIDTH*CHANNELS-1:0]    Overflow,
    output logic [CHANNELS-1:0]          Saida,
    output logic [CHANNELS-1:0]          Fim
);

    localparam logic [1:0] MODE_RETRIG   = 2'b01;
    localparam logic [1:0] MODE_PERIODIC = 2'b10;
    localparam logic [WIDTH-1:0] COUNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // ---------------------------------------------------------------------
    // Shared prescaler. The compare is >= so that lowering Prescaler below
    // the running count forces an immediate tick and wrap instead of letting
    // the counter run all the way around.
    // ---------------------------------------------------------------------
    logic [PRESCALE_WIDTH-1:0] presc_cnt_reg;
    logic                      tick;

    assign tick = (presc_cnt_reg >= Prescaler);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            presc_cnt_reg <= '0;
        end else if (tick) begin
            presc_cnt_reg <= '0;
        end else begin
            presc_cnt_reg <= presc_cnt_reg + 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Trigger history. Resets to all ones so a trigger already high when
    // reset is released is not seen as a rising edge.
    // ---------------------------------------------------------------------
    logic [CHANNELS-1:0] disparo_d_reg;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            disparo_d_reg <= '1;
        end else begin
            disparo_d_reg <= Disparo;
        end
    end

    // ---------------------------------------------------------------------
    // Per-channel counters
    // ---------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [WIDTH-1:0] count_reg;
            logic [WIDTH-1:0] count_next;
            logic             fim_reg;
            logic             fim_next;
            logic [1:0]       mode;
            logic [WIDTH-1:0] reload;
            logic             rise;

            assign mode   = Modo[2*gi +: 2];
            assign reload = Overflow[WIDTH*gi +: WIDTH];
            assign rise   = Disparo[gi] & ~disparo_d_reg[gi];

            // Priority: cancel > start > retrigger > expiry > decrement.
            // In modes 00/11 a rise while active simply falls through, so an
            // edge coincident with expiry is lost.
            always_comb begin
                count_next = count_reg;
                fim_next   = 1'b0;
                if (Cancelar[gi]) begin
                    count_next = '0;
                end else if (rise && (count_reg == '0)) begin
                    count_next = reload;
                end else if (rise && (mode == MODE_RETRIG)) begin
                    count_next = reload;
                end else if (tick && (count_reg == COUNT_ONE)) begin
                    count_next = (mode == MODE_PERIODIC) ? reload : '0;
                    fim_next   = 1'b1;
                end else if (tick && (count_reg != '0)) begin
                    count_next = count_reg - COUNT_ONE;
                end
            end

            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset) begin
                    count_reg <= '0;
                    fim_reg   <= 1'b0;
                end else begin
                    count_reg <= count_next;
                    fim_reg   <= fim_next;
                end
            end

            assign Saida[gi] = (count_reg != '0);
            assign Fim[gi]   = fim_reg;
        end
    endgenerate

endmodule
